// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine transaction controller.
// Tracks inserted credit, runs the sale / change / deny / refund sequence and
// holds each timed indication for T_HOLD cycles.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   coin1/coin5/coin10  single-cycle coin-accepted pulses (1/5/10 units)
//   sel_a/sel_b/sel_c   single-cycle product-select pulses
//   cancel              single-cycle cancel/refund pulse
//   state1..state7      one-hot status lines (credit, vend A/B/C, change, deny, refund)
//   credit, change      current credit and amount being returned
//   coin_reject         one-cycle pulse: coin not accepted
module vend_ctrl #(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 5,
  parameter int PRICE_C    = 8,
  parameter int CREDIT_MAX = 20,
  parameter int T_HOLD     = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin1,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       sel_c,
  input  logic       cancel,
  output logic       state1,
  output logic       state2,
  output logic       state3,
  output logic       state4,
  output logic       state5,
  output logic       state6,
  output logic       state7,
  output logic [4:0] credit,
  output logic [4:0] change,
  output logic       coin_reject
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND_A,
    S_VEND_B,
    S_VEND_C,
    S_CHANGE,
    S_DENY,
    S_REFUND
  } state_t;

  localparam logic [27:0] HOLD_LAST = 28'(T_HOLD - 1);
  localparam logic [5:0]  CMAX      = 6'(CREDIT_MAX);
  localparam logic [4:0]  PA        = 5'(PRICE_A);
  localparam logic [4:0]  PB        = 5'(PRICE_B);
  localparam logic [4:0]  PC        = 5'(PRICE_C);

  state_t      state, state_nxt;
  logic [4:0]  credit_nxt, change_nxt;
  logic        reject_nxt;
  logic [27:0] hold_cnt, hold_cnt_nxt;

  // Coin decode: highest-value coin wins, any other coin in the same cycle
  // is handed back.
  logic       coin_any, coin_extra;
  logic [4:0] coin_val;
  logic [5:0] credit_sum;

  // Select decode: A > B > C.
  logic       sel_any;
  logic [4:0] sel_price;
  state_t     sel_vend;

  logic       timed, hold_done;

  always_comb begin
    coin_any   = coin1 | coin5 | coin10;
    coin_extra = (coin10 & (coin5 | coin1)) | (coin5 & coin1);
    coin_val   = coin10 ? 5'd10 : (coin5 ? 5'd5 : (coin1 ? 5'd1 : 5'd0));
    // Sum one bit wider so an overflowing insert is detected, not wrapped.
    credit_sum = {1'b0, credit} + {1'b0, coin_val};

    sel_any    = sel_a | sel_b | sel_c;
    sel_price  = sel_a ? PA : (sel_b ? PB : PC);
    sel_vend   = sel_a ? S_VEND_A : (sel_b ? S_VEND_B : S_VEND_C);

    timed      = !(state inside {S_IDLE, S_CREDIT});
    hold_done  = (hold_cnt == HOLD_LAST);
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    change_nxt = change;
    reject_nxt = 1'b0;

    case (state)
      S_IDLE, S_CREDIT: begin
        // Cancel only means something once credit has been inserted.
        if (cancel && state == S_CREDIT) begin
          state_nxt  = S_REFUND;
          change_nxt = credit;
          credit_nxt = 5'd0;
          reject_nxt = coin_any;
        end else if (sel_any) begin
          // A coin arriving alongside an acted-on select is not credited.
          reject_nxt = coin_any;
          if (credit >= sel_price) begin
            state_nxt  = sel_vend;
            change_nxt = credit - sel_price;
            credit_nxt = 5'd0;
          end else begin
            state_nxt  = S_DENY;
          end
        end else if (coin_any) begin
          reject_nxt = coin_extra;
          if (credit_sum <= CMAX) begin
            state_nxt  = S_CREDIT;
            credit_nxt = credit_sum[4:0];
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      default: begin
        // Timed indication: only coins have an effect, and they bounce.
        reject_nxt = coin_any;
        if (hold_done) begin
          case (state)
            S_VEND_A, S_VEND_B, S_VEND_C:
              state_nxt = (change != 5'd0) ? S_CHANGE : S_IDLE;
            S_CHANGE, S_REFUND: begin
              state_nxt  = S_IDLE;
              change_nxt = 5'd0;
            end
            S_DENY:
              state_nxt = (credit != 5'd0) ? S_CREDIT : S_IDLE;
            default: ;
          endcase
        end
      end
    endcase

    // Counter restarts on every state change so back-to-back timed states
    // (VEND -> CHANGE) each get the full hold time.
    if (state_nxt != state || !timed) begin
      hold_cnt_nxt = 28'd0;
    end else begin
      hold_cnt_nxt = hold_cnt + 28'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      credit      <= 5'd0;
      change      <= 5'd0;
      coin_reject <= 1'b0;
      hold_cnt    <= 28'd0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      change      <= change_nxt;
      coin_reject <= reject_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  assign state1 = (state == S_CREDIT);
  assign state2 = (state == S_VEND_A);
  assign state3 = (state == S_VEND_B);
  assign state4 = (state == S_VEND_C);
  assign state5 = (state == S_CHANGE);
  assign state6 = (state == S_DENY);
  assign state7 = (state == S_REFUND);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scenarios with literal expectations, then random
// single-cycle pulses compared every cycle against a behavioural model that
// tracks which indication is showing and how many hold cycles remain.
module tb_vend_ctrl;
  localparam int T = 4;

  // Pulse vector layout: {cancel, sel_c, sel_b, sel_a, coin10, coin5, coin1}
  localparam logic [6:0] C1  = 7'h01;
  localparam logic [6:0] C5  = 7'h02;
  localparam logic [6:0] C10 = 7'h04;
  localparam logic [6:0] SA  = 7'h08;
  localparam logic [6:0] SB  = 7'h10;
  localparam logic [6:0] SC  = 7'h20;
  localparam logic [6:0] CN  = 7'h40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0;
  logic sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0, cancel = 1'b0;
  logic state1, state2, state3, state4, state5, state6, state7;
  logic [4:0] credit, change;
  logic coin_reject;
  logic [6:0] st;

  always #5 clk = ~clk;

  vend_ctrl #(.T_HOLD(T)) dut (
    .clk(clk), .rst(rst),
    .coin1(coin1), .coin5(coin5), .coin10(coin10),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .cancel(cancel),
    .state1(state1), .state2(state2), .state3(state3), .state4(state4),
    .state5(state5), .state6(state6), .state7(state7),
    .credit(credit), .change(change), .coin_reject(coin_reject)
  );

  assign st = {state7, state6, state5, state4, state3, state2, state1};

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // m_disp: which status line is lit (0 = none, 1..7 = state1..state7)
  // m_left: hold cycles still to run for a timed indication
  int m_disp = 0, m_credit = 0, m_change = 0, m_left = 0, m_rej = 0;

  initial begin
    int v, ncoin, price, idx;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_disp = 0; m_credit = 0; m_change = 0; m_left = 0; m_rej = 0;
      end else begin
        v     = coin10 ? 10 : (coin5 ? 5 : (coin1 ? 1 : 0));
        ncoin = int'(coin1) + int'(coin5) + int'(coin10);
        idx   = sel_a ? 0 : (sel_b ? 1 : 2);
        price = (idx == 0) ? 3 : ((idx == 1) ? 5 : 8);
        m_rej = 0;
        if (m_left > 0) begin
          if (ncoin > 0) m_rej = 1;
          m_left--;
          if (m_left == 0) begin
            if (m_disp >= 2 && m_disp <= 4) begin
              if (m_change != 0) begin m_disp = 5; m_left = T; end
              else m_disp = 0;
            end else if (m_disp == 5 || m_disp == 7) begin
              m_disp = 0; m_change = 0;
            end else begin
              m_disp = (m_credit != 0) ? 1 : 0;
            end
          end
        end else if (cancel && m_disp == 1) begin
          m_change = m_credit; m_credit = 0; m_disp = 7; m_left = T;
          if (ncoin > 0) m_rej = 1;
        end else if (sel_a || sel_b || sel_c) begin
          if (m_credit >= price) begin
            m_change = m_credit - price; m_credit = 0; m_disp = 2 + idx;
          end else begin
            m_disp = 6;
          end
          m_left = T;
          if (ncoin > 0) m_rej = 1;
        end else if (ncoin > 0) begin
          if (m_credit + v <= 20) begin m_credit += v; m_disp = 1; end
          else m_rej = 1;
          if (ncoin > 1) m_rej = 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [6:0] exp_st,
                     input int exp_credit, input int exp_change, input int exp_rej);
    chk({name, " status"}, int'(st), int'(exp_st));
    chk({name, " credit"}, int'(credit), exp_credit);
    chk({name, " change"}, int'(change), exp_change);
    chk({name, " coin_reject"}, int'(coin_reject), exp_rej);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("model status", int'(st), (m_disp == 0) ? 0 : (1 << (m_disp - 1)));
      chk("model credit", int'(credit), m_credit);
      chk("model change", int'(change), m_change);
      chk("model coin_reject", int'(coin_reject), m_rej);
    end
  endtask

  task automatic pulse(input logic [6:0] v);
    {cancel, sel_c, sel_b, sel_a, coin10, coin5, coin1} = v;
    @(negedge clk);
    {cancel, sel_c, sel_b, sel_a, coin10, coin5, coin1} = 7'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0] v;
    int r;
    fork
      compare_loop();
    join_none

    idle_cycles(2);
    lit("reset", 7'h00, 0, 0, 0);
    rst = 1'b0;
    idle_cycles(1);

    // Exact sale: coin5, gap, sel_b
    pulse(C5);           lit("exact coin5", 7'h01, 5, 0, 0);
    idle_cycles(1);      lit("exact gap", 7'h01, 5, 0, 0);
    pulse(SB);           lit("exact vend_b first", 7'h04, 0, 0, 0);
    idle_cycles(3);      lit("exact vend_b last", 7'h04, 0, 0, 0);
    idle_cycles(1);      lit("exact idle", 7'h00, 0, 0, 0);

    // Sale with change
    pulse(C10);          lit("change coin10", 7'h01, 10, 0, 0);
    pulse(SA);           lit("change vend_a first", 7'h02, 0, 7, 0);
    idle_cycles(3);      lit("change vend_a last", 7'h02, 0, 7, 0);
    idle_cycles(1);      lit("change state5 first", 7'h10, 0, 7, 0);
    idle_cycles(3);      lit("change state5 last", 7'h10, 0, 7, 0);
    idle_cycles(1);      lit("change idle", 7'h00, 0, 0, 0);

    // Insufficient credit, then cancel
    pulse(C1);           lit("deny coin1 a", 7'h01, 1, 0, 0);
    pulse(C1);           lit("deny coin1 b", 7'h01, 2, 0, 0);
    pulse(SC);           lit("deny first", 7'h20, 2, 0, 0);
    idle_cycles(3);      lit("deny last", 7'h20, 2, 0, 0);
    idle_cycles(1);      lit("deny back to credit", 7'h01, 2, 0, 0);
    pulse(CN);           lit("refund first", 7'h40, 0, 2, 0);
    idle_cycles(3);      lit("refund last", 7'h40, 0, 2, 0);
    idle_cycles(1);      lit("refund idle", 7'h00, 0, 0, 0);

    // Overflow and simultaneous sel_a + cancel
    pulse(C10);          lit("ovf coin10 a", 7'h01, 10, 0, 0);
    pulse(C10);          lit("ovf coin10 b", 7'h01, 20, 0, 0);
    pulse(C1);           lit("ovf reject", 7'h01, 20, 0, 1);
    idle_cycles(1);      lit("ovf reject ends", 7'h01, 20, 0, 0);
    pulse(SA | CN);      lit("ovf cancel wins", 7'h40, 0, 20, 0);
    idle_cycles(4);      lit("ovf idle", 7'h00, 0, 0, 0);

    // Coin during a vend
    pulse(C5);           lit("busy coin5", 7'h01, 5, 0, 0);
    pulse(SA);           lit("busy vend_a", 7'h02, 0, 2, 0);
    idle_cycles(1);
    pulse(C5);           lit("busy reject", 7'h02, 0, 2, 1);
    idle_cycles(1);      lit("busy vend_a last", 7'h02, 0, 2, 0);
    idle_cycles(1);      lit("busy state5", 7'h10, 0, 2, 0);
    idle_cycles(4);      lit("busy idle", 7'h00, 0, 0, 0);

    // Reset in the middle of VEND_B
    pulse(C10);
    pulse(SB);           lit("rst vend_b", 7'h04, 0, 5, 0);
    idle_cycles(1);
    #2 rst = 1'b1;
    #1 lit("rst immediate", 7'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);      lit("rst idle", 7'h00, 0, 0, 0);

    // Random pulses against the model
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 30)      v = 7'(1 << $urandom_range(0, 2));
      else if (r < 38) v = {4'b0000, 3'($urandom_range(1, 7))};
      else if (r < 48) v = 7'(8 << $urandom_range(0, 2));
      else if (r < 51) v = {1'b0, 3'($urandom_range(1, 7)), 3'b000};
      else if (r < 56) v = CN;
      else             v = 7'h00;
      pulse(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
